// File: rtl/bus_read_sequencer_pkg.sv
// Shared definitions for the bus read sequencer slice.
//   state_t      : sequencer states (IDLE, ENABLE, HOLD, GAP)
//   CNT_W        : settle counter width
//   MAX_SRC      : widest driver count supported by the enable decode
//   oe_onehot_n  : active-low one-hot enable vector for a driver index
package bus_read_sequencer_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned MAX_SRC = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENABLE,
    S_HOLD,
    S_GAP
  } state_t;

  function automatic logic [MAX_SRC-1:0] oe_onehot_n(input logic [IDX_W-1:0] idx);
    logic [MAX_SRC-1:0] v;
    v      = '1;
    v[idx] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/bus_read_sequencer_oe_decode.sv
// Index to active-low one-hot output-enable converter.
//   en   : when low, every enable is deasserted (all ones)
//   sel  : driver index
//   oe_n : per-driver active-low enable, at most one bit low
module oe_decode
  import bus_read_sequencer_pkg::*;
#(
  parameter int unsigned NSRC  = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [NSRC-1:0]  oe_n
);

  logic [MAX_SRC-1:0] full_n;

  always_comb begin
    full_n = oe_onehot_n(IDX_W'(sel));
    oe_n   = en ? full_n[NSRC-1:0] : '1;
  end

  // Decode bits above NSRC never reach a driver.
  generate
    if (NSRC < MAX_SRC) begin : g_hi
      logic unused_hi;
      assign unused_hi = &full_n[MAX_SRC-1:NSRC];
    end
  endgenerate

endmodule

// File: rtl/bus_read_sequencer.sv
// Reader end of a shared tristate bus fed by NSRC registered drivers.
// A request selects one driver, enables it for SETTLE+1 cycles, captures
// the bus, releases it and offers the byte over a valid/ready handshake.
// A one-cycle GAP separates successive enables.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   REQ, SRC_SEL : read request and driver index (sampled in IDLE only)
//   BUS_I        : shared bus value
//   OENB_N       : registered active-low driver enables
//   DATA_O/VALID/READY : captured byte handshake
//   BUSY         : sequencer not idle
//   ERR          : one-cycle pulse on an out-of-range request
module bus_read_sequencer
  import bus_read_sequencer_pkg::*;
#(
  parameter int unsigned NSRC   = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned SEL_W  = 2
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             REQ,
  input  logic [SEL_W-1:0] SRC_SEL,
  input  logic [WIDTH-1:0] BUS_I,
  output logic [NSRC-1:0]  OENB_N,
  output logic [WIDTH-1:0] DATA_O,
  output logic             VALID,
  input  logic             READY,
  output logic             BUSY,
  output logic             ERR
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NSRC-1:0]    oenb_q, oenb_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic               sel_ok;
  logic               accept;
  logic [NSRC-1:0]    dec_oe_n;

  assign sel_ok = (32'(SRC_SEL) < NSRC);
  assign accept = (state_q == S_IDLE) && REQ && sel_ok;

  oe_decode #(
    .NSRC  (NSRC),
    .SEL_W (SEL_W)
  ) u_oe_decode (
    .en   (accept),
    .sel  (SRC_SEL),
    .oe_n (dec_oe_n)
  );

  // Reset releases the bus asynchronously, so the enable register resets
  // to all ones alongside the state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      oenb_q  <= '1;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oenb_q  <= oenb_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    oenb_d  = oenb_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (REQ) begin
          if (sel_ok) begin
            oenb_d  = dec_oe_n;
            cnt_d   = CNT_W'(SETTLE);
            state_d = S_ENABLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_ENABLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          data_d  = BUS_I;
          oenb_d  = '1;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (READY) begin
          valid_d = 1'b0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        oenb_d  = '1;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign OENB_N = oenb_q;
  assign DATA_O = data_q;
  assign VALID  = valid_q;
  assign ERR    = err_q;
  assign BUSY   = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_read_sequencer.sv
module tb_bus_read_sequencer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RESET_N;

  // u0: NSRC=4, SETTLE=1
  logic       req0, ready0, valid0, busy0, err0;
  logic [1:0] sel0;
  logic [7:0] bus0, data0;
  logic [3:0] oe0;

  // u1: NSRC=3, SETTLE=1
  logic       req1, ready1, valid1, busy1, err1;
  logic [1:0] sel1;
  logic [7:0] bus1, data1;
  logic [2:0] oe1;

  // u2: NSRC=4, SETTLE=0
  logic       req2, ready2, valid2, busy2, err2;
  logic [1:0] sel2;
  logic [7:0] bus2, data2;
  logic [3:0] oe2;

  int checks = 0;
  int errors = 0;

  // Driver models: an enabled driver puts its byte on the bus.
  always_comb begin
    if (!oe0[2])      bus0 = 8'hA5;
    else if (!oe0[1]) bus0 = 8'h22;
    else if (!oe0[0]) bus0 = 8'h11;
    else              bus0 = 8'hFF;
    bus1 = 8'h5A;
    bus2 = !oe2[0] ? 8'h3C : 8'h00;
  end

  bus_read_sequencer #(.NSRC(4), .WIDTH(8), .SETTLE(1), .SEL_W(2)) u0 (
    .CLK(CLK), .RESET_N(RESET_N), .REQ(req0), .SRC_SEL(sel0), .BUS_I(bus0),
    .OENB_N(oe0), .DATA_O(data0), .VALID(valid0), .READY(ready0),
    .BUSY(busy0), .ERR(err0));

  bus_read_sequencer #(.NSRC(3), .WIDTH(8), .SETTLE(1), .SEL_W(2)) u1 (
    .CLK(CLK), .RESET_N(RESET_N), .REQ(req1), .SRC_SEL(sel1), .BUS_I(bus1),
    .OENB_N(oe1), .DATA_O(data1), .VALID(valid1), .READY(ready1),
    .BUSY(busy1), .ERR(err1));

  bus_read_sequencer #(.NSRC(4), .WIDTH(8), .SETTLE(0), .SEL_W(2)) u2 (
    .CLK(CLK), .RESET_N(RESET_N), .REQ(req2), .SRC_SEL(sel2), .BUS_I(bus2),
    .OENB_N(oe2), .DATA_O(data2), .VALID(valid2), .READY(ready2),
    .BUSY(busy2), .ERR(err2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0] prev;
    int         last_start;
    int         nstarts;
    logic       exp_sel;
    int         w;

    RESET_N = 1'b0;
    req0 = 1'b0; ready0 = 1'b0; sel0 = '0;
    req1 = 1'b0; ready1 = 1'b0; sel1 = '0;
    req2 = 1'b0; ready2 = 1'b0; sel2 = '0;

    // Reset release
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_oe_in_reset", oe0, 4'hF);
    RESET_N = 1'b1;
    tick();
    chk("rst_oe", oe0, 4'hF);
    chk("rst_valid", valid0, 1'b0);
    chk("rst_data", data0, 8'h00);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_err", err0, 1'b0);

    // Basic read, SETTLE=1, driver 2
    sel0 = 2'd2; req0 = 1'b1;
    tick();
    chk("rd_oe_c1", oe0, 4'b1011);
    chk("rd_busy", busy0, 1'b1);
    chk("rd_valid_c1", valid0, 1'b0);
    req0 = 1'b0;
    tick();
    chk("rd_oe_c2", oe0, 4'b1011);
    chk("rd_valid_c2", valid0, 1'b0);
    tick();
    chk("rd_oe_c3", oe0, 4'hF);
    chk("rd_data", data0, 8'hA5);
    chk("rd_valid", valid0, 1'b1);

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_data", data0, 8'hA5);
      chk("bp_valid", valid0, 1'b1);
      chk("bp_busy", busy0, 1'b1);
    end
    ready0 = 1'b1;
    tick();
    chk("acc_valid", valid0, 1'b0);
    chk("acc_gap_busy", busy0, 1'b1);
    chk("acc_gap_oe", oe0, 4'hF);
    tick();
    chk("acc_idle_busy", busy0, 1'b0);
    chk("acc_data_kept", data0, 8'hA5);

    // Back-to-back requests, drivers 0/1 alternating
    sel0 = 2'd0; req0 = 1'b1;
    prev = oe0;
    last_start = -1;
    nstarts = 0;
    exp_sel = 1'b0;
    for (int c = 0; c < 22; c++) begin
      tick();
      chk("b2b_onehot", 32'($countones(~oe0) <= 1), 32'd1);
      if (oe0 != prev && oe0 != 4'hF) begin
        chk("b2b_dead_cycle", prev, 4'hF);
        chk("b2b_sel", oe0, exp_sel ? 4'b1101 : 4'b1110);
        if (last_start >= 0) chk("b2b_spacing", c - last_start, 5);
        last_start = c;
        nstarts++;
        exp_sel = ~exp_sel;
        sel0 = {1'b0, exp_sel};
      end
      prev = oe0;
    end
    chk("b2b_count", nstarts, 5);
    req0 = 1'b0;
    w = 0;
    while (busy0 && w < 10) begin
      tick();
      w++;
    end
    chk("b2b_idle", busy0, 1'b0);
    chk("b2b_last_data", data0, 8'h11);

    // Reset asserted during ENABLE
    ready0 = 1'b0; sel0 = 2'd1; req0 = 1'b1;
    tick();
    chk("rstmid_oe_before", oe0, 4'b1101);
    req0 = 1'b0;
    RESET_N = 1'b0;
    #1;
    chk("rstmid_oe_async", oe0, 4'hF);
    chk("rstmid_valid", valid0, 1'b0);
    chk("rstmid_data", data0, 8'h00);
    chk("rstmid_busy", busy0, 1'b0);
    #3;
    RESET_N = 1'b1;
    tick();
    chk("rstmid_oe_after", oe0, 4'hF);
    chk("rstmid_busy_after", busy0, 1'b0);

    // Rejected select on NSRC=3
    sel1 = 2'd3; req1 = 1'b1;
    tick();
    chk("rej_err", err1, 1'b1);
    chk("rej_oe", oe1, 3'b111);
    chk("rej_busy", busy1, 1'b0);
    req1 = 1'b0;
    tick();
    chk("rej_err_drop", err1, 1'b0);
    chk("rej_oe_after", oe1, 3'b111);
    sel1 = 2'd2; req1 = 1'b1;
    tick();
    chk("u1_ok_oe", oe1, 3'b011);
    chk("u1_ok_err", err1, 1'b0);
    req1 = 1'b0; ready1 = 1'b1;

    // SETTLE=0 corner
    sel2 = 2'd0; req2 = 1'b1;
    tick();
    chk("s0_oe_c1", oe2, 4'b1110);
    chk("s0_busy", busy2, 1'b1);
    req2 = 1'b0;
    tick();
    chk("s0_oe_c2", oe2, 4'hF);
    chk("s0_data", data2, 8'h3C);
    chk("s0_valid", valid2, 1'b1);
    sel2 = 2'd1; req2 = 1'b1;
    tick();
    chk("s0_hold_req_oe", oe2, 4'hF);
    chk("s0_hold_valid", valid2, 1'b1);
    ready2 = 1'b1;
    tick();
    chk("s0_gap_valid", valid2, 1'b0);
    chk("s0_gap_oe", oe2, 4'hF);
    chk("s0_gap_busy", busy2, 1'b1);
    tick();
    chk("s0_idle_oe", oe2, 4'hF);
    chk("s0_idle_busy", busy2, 1'b0);
    req2 = 1'b0;
    tick();
    chk("s0_no_enable", oe2, 4'hF);
    chk("s0_data_kept", data2, 8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
